// File: rtl/gpio_led_ctrl.sv
// AHB-Lite GPIO/LED block: 32-bit tristate GPIO with synchronized input and rising-edge IRQ,
// plus 16 LEDs with a divider-driven blink phase applied through a mask.
module gpio_led_ctrl #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter logic [31:0] BLINK_DIV_RST = 32'd50_000_000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    inout  wire  [31:0] GPIO,
    output logic [15:0] LED,
    output logic        IRQ
);

    localparam logic [2:0] A_GPIO_OUT   = 3'd0;
    localparam logic [2:0] A_DIR        = 3'd1;
    localparam logic [2:0] A_GPIO_IN    = 3'd2;
    localparam logic [2:0] A_LED_REG    = 3'd3;
    localparam logic [2:0] A_BLINK_MASK = 3'd4;
    localparam logic [2:0] A_BLINK_DIV  = 3'd5;
    localparam logic [2:0] A_IRQ_EN     = 3'd6;
    localparam logic [2:0] A_IRQ_STAT   = 3'd7;

    // AHB data-phase context
    logic                        dph_vld_q, dph_vld_d;
    logic                        dph_wr_q, dph_wr_d;
    logic                        dph_word_q, dph_word_d;
    logic [2:0]                  dph_addr_q, dph_addr_d;

    // Register file
    logic [31:0]                 gpio_out_q, gpio_out_d;
    logic [31:0]                 dir_q, dir_d;
    logic [15:0]                 led_reg_q, led_reg_d;
    logic [15:0]                 blink_mask_q, blink_mask_d;
    logic [31:0]                 blink_div_q, blink_div_d;
    logic [31:0]                 irq_en_q, irq_en_d;
    logic [31:0]                 irq_stat_q, irq_stat_d;

    // Input path, blink scheduler, registered outputs
    logic [SYNC_STAGES-1:0][31:0] sync_q, sync_d;
    logic [31:0]                 edge_q, edge_d;
    logic [31:0]                 cnt_q, cnt_d;
    logic                        phase_q, phase_d;
    logic [15:0]                 led_q, led_d;
    logic                        irq_q, irq_d;

    logic [31:0]                 gpio_in;
    logic [31:0]                 rise;
    logic                        wr_en;
    logic                        accept;
    logic                        unused_bits;

    assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0]};

    assign accept  = HSEL & HTRANS[1] & HREADY;
    assign wr_en   = dph_vld_q & dph_wr_q & dph_word_q;
    assign gpio_in = sync_q[SYNC_STAGES-1];
    assign rise    = gpio_in & ~edge_q;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign LED       = led_q;
    assign IRQ       = irq_q;

    for (genvar i = 0; i < 32; i++) begin : g_pad
        assign GPIO[i] = dir_q[i] ? gpio_out_q[i] : 1'bz;
    end

    always_comb begin
        dph_vld_d    = accept;
        dph_wr_d     = HWRITE;
        dph_word_d   = (HSIZE == 3'b010);
        dph_addr_d   = HADDR[4:2];

        gpio_out_d   = gpio_out_q;
        dir_d        = dir_q;
        led_reg_d    = led_reg_q;
        blink_mask_d = blink_mask_q;
        blink_div_d  = blink_div_q;
        irq_en_d     = irq_en_q;
        irq_stat_d   = irq_stat_q;

        sync_d       = {sync_q[SYNC_STAGES-2:0], GPIO};
        edge_d       = gpio_in;

        if (wr_en) begin
            case (dph_addr_q)
                A_GPIO_OUT:   gpio_out_d   = HWDATA;
                A_DIR:        dir_d        = HWDATA;
                A_LED_REG:    led_reg_d    = HWDATA[15:0];
                A_BLINK_MASK: blink_mask_d = HWDATA[15:0];
                A_BLINK_DIV:  blink_div_d  = HWDATA;
                A_IRQ_EN:     irq_en_d     = HWDATA;
                A_IRQ_STAT:   irq_stat_d   = irq_stat_q & ~HWDATA;
                default:      ;
            endcase
        end
        // Set is applied after the clear so a coincident edge keeps the bit.
        irq_stat_d = irq_stat_d | (rise & irq_en_q);

        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (wr_en && dph_addr_q == A_BLINK_DIV) begin
            cnt_d   = (HWDATA == 32'd0) ? 32'd0 : HWDATA - 32'd1;
            phase_d = 1'b0;
        end else if (blink_div_q == 32'd0) begin
            cnt_d   = 32'd0;
            phase_d = 1'b0;
        end else if (cnt_q == 32'd0) begin
            cnt_d   = blink_div_q - 32'd1;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q - 32'd1;
        end

        led_d = led_reg_q & ~(blink_mask_q & {16{phase_q}});
        irq_d = |(irq_stat_q & irq_en_q);
    end

    always_comb begin
        HRDATA = 32'd0;
        if (dph_vld_q && !dph_wr_q) begin
            case (dph_addr_q)
                A_GPIO_OUT:   HRDATA = gpio_out_q;
                A_DIR:        HRDATA = dir_q;
                A_GPIO_IN:    HRDATA = gpio_in;
                A_LED_REG:    HRDATA = {16'd0, led_reg_q};
                A_BLINK_MASK: HRDATA = {16'd0, blink_mask_q};
                A_BLINK_DIV:  HRDATA = blink_div_q;
                A_IRQ_EN:     HRDATA = irq_en_q;
                A_IRQ_STAT:   HRDATA = irq_stat_q;
                default:      HRDATA = 32'd0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            dph_vld_q    <= 1'b0;
            dph_wr_q     <= 1'b0;
            dph_word_q   <= 1'b0;
            dph_addr_q   <= 3'd0;
            gpio_out_q   <= 32'd0;
            dir_q        <= 32'd0;
            led_reg_q    <= 16'd0;
            blink_mask_q <= 16'd0;
            blink_div_q  <= BLINK_DIV_RST;
            irq_en_q     <= 32'd0;
            irq_stat_q   <= 32'd0;
            sync_q       <= '0;
            edge_q       <= 32'd0;
            cnt_q        <= 32'd0;
            phase_q      <= 1'b0;
            led_q        <= 16'd0;
            irq_q        <= 1'b0;
        end else begin
            dph_vld_q    <= dph_vld_d;
            dph_wr_q     <= dph_wr_d;
            dph_word_q   <= dph_word_d;
            dph_addr_q   <= dph_addr_d;
            gpio_out_q   <= gpio_out_d;
            dir_q        <= dir_d;
            led_reg_q    <= led_reg_d;
            blink_mask_q <= blink_mask_d;
            blink_div_q  <= blink_div_d;
            irq_en_q     <= irq_en_d;
            irq_stat_q   <= irq_stat_d;
            sync_q       <= sync_d;
            edge_q       <= edge_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            led_q        <= led_d;
            irq_q        <= irq_d;
        end
    end

endmodule

// File: tb/tb_gpio_led_ctrl.sv
// Randomized bench for gpio_led_ctrl against a register-level reference model.
module tb_gpio_led_ctrl;

    localparam int SYNC = 2;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = '0;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'b010;
    logic [31:0] HWDATA = '0;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    wire  [31:0] GPIO;
    logic [15:0] LED;
    logic        IRQ;

    logic [31:0] tb_en = '1;
    logic [31:0] tb_val = '0;
    logic [31:0] mdl [8];
    int          n_tests = 0;
    int          n_fail = 0;

    for (genvar i = 0; i < 32; i++) begin : g_drv
        assign GPIO[i] = tb_en[i] ? tb_val[i] : 1'bz;
    end

    gpio_led_ctrl #(.SYNC_STAGES(SYNC)) dut (
        .CLK(CLK), .RESET(RESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .GPIO(GPIO),
        .LED(LED), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wmask(input int idx);
        return (idx == 3 || idx == 4) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] pad_val();
        return (mdl[1] & mdl[0]) | (~mdl[1] & tb_val);
    endfunction

    function automatic logic [31:0] exp_rd(input int idx);
        return (idx == 2) ? pad_val() : mdl[idx];
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 8; i++) mdl[i] = 32'd0;
        mdl[5] = 32'd50_000_000;
    endtask

    task automatic mdl_wr(input int idx, input logic [31:0] d, input logic [2:0] sz);
        if (sz != 3'b010 || idx == 2) return;
        if (idx == 7) mdl[7] = mdl[7] & ~d;
        else mdl[idx] = d & wmask(idx);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic addr_phase(input int idx, input logic wr, input logic [2:0] sz);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HSIZE = sz;
        HADDR = ($urandom() & 32'hFFFF_FFE0) | (32'(idx) << 2);
    endtask

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b010;
        HADDR = $urandom();
    endtask

    task automatic bus_wr(input int idx, input logic [31:0] d, input logic [2:0] sz);
        addr_phase(idx, 1'b1, sz);
        @(posedge CLK); #1;
        bus_idle();
        HWDATA = d;
        mdl_wr(idx, d, sz);
        @(negedge CLK);
        chk("wr_hresp", HRESP, 0);
        chk("wr_hreadyout", HREADYOUT, 1);
        @(posedge CLK); #1;
        tb_en = ~mdl[1];
    endtask

    task automatic bus_rd(input int idx, input string tag);
        addr_phase(idx, 1'b0, 3'b010);
        @(posedge CLK); #1;
        bus_idle();
        @(negedge CLK);
        chk(tag, HRDATA, exp_rd(idx));
        @(posedge CLK); #1;
    endtask

    task automatic bus_wr_rd(input int idx, input logic [31:0] d, input logic [2:0] sz);
        addr_phase(idx, 1'b1, sz);
        @(posedge CLK); #1;
        addr_phase(idx, 1'b0, 3'b010);
        HWDATA = d;
        mdl_wr(idx, d, sz);
        @(posedge CLK); #1;
        tb_en = ~mdl[1];
        bus_idle();
        @(negedge CLK);
        chk("b2b_rdata", HRDATA, exp_rd(idx));
        chk("b2b_hreadyout", HREADYOUT, 1);
        @(posedge CLK); #1;
    endtask

    task automatic rd_all(input string tag);
        for (int i = 0; i < 8; i++) bus_rd(i, tag);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx;
        int          n;
        logic [31:0] d;
        logic [2:0]  sz;
        logic [15:0] exp_led;

        mdl_reset();
        tb_val = $urandom();
        tb_en  = '1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_led", LED, 0);
        chk("rst_irq", IRQ, 0);
        chk("rst_hrdata", HRDATA, 0);
        chk("rst_gpio_hiz", GPIO, tb_val);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        chk("idle_hrdata", HRDATA, 0);
        idle(SYNC + 2);
        rd_all("rst_regs");

        // Random register traffic; blink phase stays 1 for the reset-time divider
        for (int it = 0; it < 30; it++) begin
            idx = $urandom_range(0, 4);
            d   = $urandom();
            sz  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 1)) : 3'b010;
            if (idx == 2) bus_wr(idx, d, sz);
            else if ($urandom_range(0, 1) == 1) bus_wr_rd(idx, d, sz);
            else begin
                bus_wr(idx, d, sz);
                bus_rd(idx, "rand_rd");
            end
            if (it % 5 == 4) begin
                tb_val = $urandom();
                idle(SYNC + 2);
                bus_rd(2, "gpio_in");
                chk("led_phase1", LED, mdl[3][15:0] & ~mdl[4][15:0]);
            end
        end

        // Direction / output / zero-wait readback
        bus_wr(1, 32'hFFFF_0000, 3'b010);
        tb_val = $urandom();
        bus_wr_rd(0, 32'hA5A5_1234, 3'b010);
        @(negedge CLK);
        chk("gpio_hi", GPIO[31:16], 16'hA5A5);
        chk("gpio_lo_hiz", GPIO[15:0], tb_val[15:0]);
        @(posedge CLK); #1;
        idle(SYNC);
        bus_rd(2, "gpio_in_mixed");

        // Blink: fixed divider then a random one
        bus_wr(3, 32'h0000_00FF, 3'b010);
        bus_wr(4, 32'h0000_000F, 3'b010);
        for (int pass = 0; pass < 2; pass++) begin
            n = (pass == 0) ? 4 : $urandom_range(1, 6);
            bus_wr(5, 32'(n), 3'b010);
            for (int k = 1; k <= 4 * n + 2; k++) begin
                @(posedge CLK);
                @(negedge CLK);
                exp_led = (((k - 1) / n) % 2 == 1) ? 16'h00F0 : 16'h00FF;
                chk("blink_led", LED, exp_led);
            end
            @(posedge CLK); #1;
        end
        bus_wr(5, 32'd0, 3'b010);
        for (int k = 1; k <= 6; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            chk("blink_off", LED, 16'h00FF);
        end
        @(posedge CLK); #1;
        bus_rd(5, "div_zero");

        // Sub-word writes are ignored
        bus_wr(3, 32'h0000_1234, 3'b000);
        bus_wr(3, 32'h0000_5678, 3'b001);
        bus_rd(3, "subword_led_reg");

        // Rising-edge interrupt
        bus_wr(1, 32'd0, 3'b010);
        tb_val[0] = 1'b0;
        bus_wr(6, 32'h1, 3'b010);
        idle(SYNC + 2);
        bus_rd(7, "stat_clear");
        tb_val[0] = 1'b1;
        for (int c = 1; c <= SYNC + 2; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            chk("irq_latency", IRQ, (c >= SYNC + 2) ? 1 : 0);
        end
        mdl[7] = 32'h1;
        @(posedge CLK); #1;
        bus_rd(7, "stat_set");
        bus_wr(7, 32'h1, 3'b010);
        @(negedge CLK);
        chk("irq_hold", IRQ, 1);
        @(negedge CLK);
        chk("irq_w1c", IRQ, 0);
        @(posedge CLK); #1;

        // Clear coinciding with a new edge: set wins
        tb_val[0] = 1'b0;
        idle(SYNC + 2);
        tb_val[0] = 1'b1;
        @(posedge CLK); #1;
        bus_wr(7, 32'h1, 3'b010);
        mdl[7] = mdl[7] | 32'h1;
        bus_rd(7, "collision_stat");
        chk("collision_irq", IRQ, 1);

        // Reset in the middle of a write data phase
        bus_wr(3, 32'h0000_BEEF, 3'b010);
        bus_wr(0, $urandom(), 3'b010);
        bus_wr(1, 32'hFFFF_FFFF, 3'b010);
        @(negedge CLK);
        chk("pre_rst_led", LED, 16'hBEEF);
        chk("pre_rst_irq", IRQ, 1);
        @(posedge CLK); #1;
        addr_phase(3, 1'b1, 3'b010);
        @(posedge CLK); #1;
        bus_idle();
        HWDATA = 32'h0000_1111;
        RESET  = 1'b0;
        tb_en  = '1;
        tb_val = $urandom();
        mdl_reset();
        @(negedge CLK);
        chk("mid_rst_led", LED, 0);
        chk("mid_rst_irq", IRQ, 0);
        chk("mid_rst_hrdata", HRDATA, 0);
        chk("mid_rst_gpio_hiz", GPIO, tb_val);
        @(posedge CLK);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        chk("post_rst_hrdata", HRDATA, 0);
        chk("post_rst_led", LED, 0);
        @(posedge CLK); #1;
        idle(SYNC + 1);
        rd_all("post_rst_regs");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
